piezo_rx_detector: RTL and testbench
====================================

// Module: piezo_rx_detector
// PURPOSE
//  Conditions the raw ultrasonic comparator input before it reaches the PTP sync
//  block. Synchronises the input, rejects glitches and ignores self-reception
//  during and after our own transmit burst. Drives a clean, fixed-width
//  detection level to ptp_sync.piezo_interface_in. Timestamps each detection,
//  compensated for filter latency, and keeps saturating event/reject counters
//  for debug via Avalon.
// PARAMETERS
//  SYNC_STAGES   2      synchroniser flops on piezo_raw_in (>=2)
//  FILT_LEN      8      consecutive high samples required to qualify (>=1)
//  PULSE_HOLD    16     cycles det_out stays high per detection (>=1)
//  BLANK_CYCLES  20000  echo/ringing blanking after HOLD (>=0)
//  TX_GUARD      2500   cycles input is ignored after tx_active_in falls
//  TS_WIDTH      32     timestamp counter width
// PORTS
//  clock           in   1         system clock, 50 MHz
//  reset_n         in   1         asynchronous reset, active-low
//  enable          in   1         1 = detector armed
//  piezo_raw_in    in   1         async comparator output
//  tx_active_in    in   1         own transmit active (piezo_interface_out), same clock domain
//  clear_counts    in   1         1-cycle strobe, zeroes det_count and rej_count
//  det_out         out  1         clean detection level, to ptp_sync
//  det_pulse       out  1         1-cycle strobe on the first det_out cycle
//  det_timestamp   out  TS_WIDTH  ts_cnt at the qualified raw edge
//  det_count       out  16        detections, saturating
//  rej_count       out  16        aborted qualifications (glitches), saturating
// BEHAVIOUR
//  - Reset values: all outputs 0, ts_cnt 0, guard_cnt 0, FSM = IDLE, sync chain 0.
//  - ts_cnt: free-running, +1 every cycle regardless of enable; wraps mod 2^TS_WIDTH.
//  - s = last synchroniser stage.
//  - guard = tx_active_in | (guard_cnt != 0).
//    - guard_cnt loads TX_GUARD while tx_active_in = 1.
//    - Otherwise guard_cnt decrements to 0.
//  - FSM states, all registered:
//    - IDLE: if s & ~guard: FILT_LEN = 1 -> HOLD, else -> QUAL with qcnt = 1.
//    - QUAL:
//      - s = 0 -> IDLE, rej_count++.
//      - guard -> IDLE, no reject count.
//      - s = 1 -> qcnt++; when qcnt reaches FILT_LEN -> HOLD.
//    - HOLD: det_out = 1 for exactly PULSE_HOLD cycles; input ignored; guard ignored.
//      Then BLANK, or IDLE if BLANK_CYCLES = 0.
//    - BLANK: input ignored for BLANK_CYCLES cycles, then IDLE.
//  - On the HOLD-entry edge, these update together: det_out <= 1, det_pulse <= 1,
//    det_count++, det_timestamp <= ts_cnt - (SYNC_STAGES + FILT_LEN - 1) (mod 2^TS_WIDTH).
//  - Latency: raw rising at edge k, held high -> det_out high after edge k+SYNC_STAGES+FILT_LEN.
//    - det_timestamp equals ts_cnt value present at edge k (value sampled at edge k).
//  - Counters saturate at 16'hFFFF.
//    - clear_counts has priority over a same-cycle increment; the result is 0.
//  - enable = 0: next edge FSM -> IDLE, det_out/det_pulse 0; counters and det_timestamp hold.
//    - Re-enable starts in IDLE; a raw level already high qualifies as a fresh edge.
//  - Raw input still high after BLANK re-qualifies; the bench keeps raw pulses short.
//  - reset_n low mid-operation: outputs clear immediately (async); released synchronously.
// STRUCTURE
//  - piezo_defs.vh: FSM state encodings (IDLE/QUAL/HOLD/BLANK), default parameter constants.
//  - Sub-module piezo_in_sync: SYNC_STAGES-deep flop chain with async active-low reset.
//  - Top: FSM, qcnt/hold/blank counter (shared), guard_cnt, ts_cnt, stat counters.
// TESTING  (bench params: SYNC_STAGES=2 FILT_LEN=4 PULSE_HOLD=8 BLANK_CYCLES=100
//          TX_GUARD=10 TS_WIDTH=32)
//  1. Raw high at ts=1000 for 50 cycles.
//     -> det_out high 8 cycles from ts=1006; det_pulse once; det_timestamp=1000; det_count=1.
//  2. Raw high 3 cycles.
//     -> no det_out; rej_count=1; det_count unchanged.
//  3. After det_out drop, raw pulses 20 cycles later.
//     -> ignored (BLANK); pulse 120 cycles after drop detected; det_count=2.
//  4. tx_active 5 cycles, raw pulse 5 cycles after tx falls.
//     -> ignored, no reject; pulse 15 cycles after tx falls -> detected.
//  5. reset_n low during HOLD.
//     -> det_out=0 same cycle; counters 0; after release a new pulse detects normally.
//  6. TS_WIDTH=8, raw edge at ts=254.
//     -> det_timestamp=254 with the wrap to 4 occurring mid-latency.
//     -> clear_counts coincident with detection -> det_count=0.

Source files
------------

// File: rtl/piezo_rx_detector_pkg.sv
// ---------------------------------------------------------------------------
// piezo_rx_detector_pkg
// Shared types and constants for the ultrasonic receive detector.
//   det_state_e   : detector FSM states (IDLE/QUAL/HOLD/BLANK)
//   DEF_*         : default parameter values used by piezo_rx_detector
//   stat_cnt_t    : debug event/reject counter pair
//   sat_inc()     : saturating counter update with clear priority
//   max3()        : elaboration-time helper for sizing the shared counter
// ---------------------------------------------------------------------------
package piezo_rx_detector_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_QUAL  = 2'd1,
    ST_HOLD  = 2'd2,
    ST_BLANK = 2'd3
  } det_state_e;

  localparam int DEF_SYNC_STAGES  = 2;
  localparam int DEF_FILT_LEN     = 8;
  localparam int DEF_PULSE_HOLD   = 16;
  localparam int DEF_BLANK_CYCLES = 20000;
  localparam int DEF_TX_GUARD     = 2500;
  localparam int DEF_TS_WIDTH     = 32;

  localparam int          STAT_W   = 16;
  localparam logic [15:0] STAT_MAX = 16'hFFFF;

  typedef struct packed {
    logic [STAT_W-1:0] det;
    logic [STAT_W-1:0] rej;
  } stat_cnt_t;

  // Clear wins over a same-cycle increment; counters stick at all-ones.
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v,
                                                 input logic clr,
                                                 input logic inc);
    logic [STAT_W-1:0] r;
    r = v;
    if (clr)                        r = '0;
    else if (inc && v != STAT_MAX)  r = v + STAT_W'(1);
    return r;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/piezo_rx_detector_in_sync.sv
// ---------------------------------------------------------------------------
// piezo_rx_detector_in_sync
// STAGES-deep synchroniser for the asynchronous comparator output.
//   clock   : system clock
//   reset_n : asynchronous active-low reset, clears the chain to 0
//   d       : asynchronous input
//   q       : synchronised output (last flop of the chain)
// ---------------------------------------------------------------------------
module piezo_rx_detector_in_sync #(
  parameter int STAGES = 2
) (
  input  logic clock,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) chain <= '0;
    else          chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/piezo_rx_detector.sv
// ---------------------------------------------------------------------------
// piezo_rx_detector
// Cleans the raw ultrasonic comparator level for the PTP sync block:
// synchronises it, requires FILT_LEN consecutive high samples, then drives a
// fixed PULSE_HOLD-cycle detection level followed by a BLANK_CYCLES echo
// blanking window. Input is ignored while we transmit and for TX_GUARD cycles
// afterwards. Each detection is timestamped with the free-running ts_cnt
// value at the raw edge (filter + synchroniser latency removed).
//   clock          : system clock
//   reset_n        : asynchronous active-low reset; deassertion is expected
//                    to be synchronous to clock (handled upstream)
//   enable         : 1 = detector armed; 0 forces IDLE on the next edge
//   piezo_raw_in   : asynchronous comparator output
//   tx_active_in   : own transmit burst active (clock domain)
//   clear_counts   : one-cycle strobe, zeroes det_count and rej_count
//   det_out        : clean detection level
//   det_pulse      : strobe on the first det_out cycle
//   det_timestamp  : ts_cnt at the qualified raw edge
//   det_count      : saturating detection count
//   rej_count      : saturating aborted-qualification count
// ---------------------------------------------------------------------------
module piezo_rx_detector
  import piezo_rx_detector_pkg::*;
#(
  parameter int SYNC_STAGES  = DEF_SYNC_STAGES,
  parameter int FILT_LEN     = DEF_FILT_LEN,
  parameter int PULSE_HOLD   = DEF_PULSE_HOLD,
  parameter int BLANK_CYCLES = DEF_BLANK_CYCLES,
  parameter int TX_GUARD     = DEF_TX_GUARD,
  parameter int TS_WIDTH     = DEF_TS_WIDTH
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                enable,
  input  logic                piezo_raw_in,
  input  logic                tx_active_in,
  input  logic                clear_counts,
  output logic                det_out,
  output logic                det_pulse,
  output logic [TS_WIDTH-1:0] det_timestamp,
  output logic [15:0]         det_count,
  output logic [15:0]         rej_count
);

  // One counter serves qualification, hold and blanking, since only one of
  // those phases is ever active.
  localparam int CW = $clog2(max3(FILT_LEN, PULSE_HOLD, BLANK_CYCLES) + 1);
  // +2 keeps the width at least 1 when TX_GUARD = 0.
  localparam int GW = $clog2(TX_GUARD + 2);

  localparam logic [CW-1:0]       QUAL_LAST = CW'(FILT_LEN - 1);
  localparam logic [CW-1:0]       HOLD_N    = CW'(PULSE_HOLD);
  localparam logic [CW-1:0]       BLANK_N   = CW'(BLANK_CYCLES);
  localparam logic [GW-1:0]       GUARD_N   = GW'(TX_GUARD);
  // Edges between the raw sample and the HOLD-entry edge.
  localparam logic [TS_WIDTH-1:0] TS_LAT    = TS_WIDTH'(SYNC_STAGES + FILT_LEN - 1);

  det_state_e          state, state_nxt;
  logic [CW-1:0]       cnt, cnt_nxt;
  logic [GW-1:0]       guard_cnt;
  logic [TS_WIDTH-1:0] ts_cnt;
  stat_cnt_t           stats;
  logic                s;
  logic                guard;
  logic                enter_hold;
  logic                reject;

  // -------------------------------------------------------------------------
  // Input synchroniser
  // -------------------------------------------------------------------------
  piezo_rx_detector_in_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .d       (piezo_raw_in),
    .q       (s)
  );

  // -------------------------------------------------------------------------
  // Transmit guard: reloads while transmitting, then counts down so the
  // ringing of our own transducer is not taken as a reception.
  // -------------------------------------------------------------------------
  assign guard = tx_active_in | (guard_cnt != '0);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)               guard_cnt <= '0;
    else if (tx_active_in)      guard_cnt <= GUARD_N;
    else if (guard_cnt != '0)   guard_cnt <= guard_cnt - GW'(1);
  end

  // -------------------------------------------------------------------------
  // Free-running timestamp counter, independent of enable
  // -------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) ts_cnt <= '0;
    else          ts_cnt <= ts_cnt + TS_WIDTH'(1);
  end

  // -------------------------------------------------------------------------
  // Detector FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    enter_hold = 1'b0;
    reject     = 1'b0;
    if (!enable) begin
      state_nxt = ST_IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (s && !guard) begin
            cnt_nxt = CW'(1);
            if (FILT_LEN == 1) begin
              state_nxt  = ST_HOLD;
              enter_hold = 1'b1;
            end else begin
              state_nxt  = ST_QUAL;
            end
          end
        end
        ST_QUAL: begin
          // A drop mid-qualification is a glitch; a guard hit is not.
          if (!s) begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
            reject    = 1'b1;
          end else if (guard) begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
          end else if (cnt == QUAL_LAST) begin
            state_nxt  = ST_HOLD;
            cnt_nxt    = CW'(1);
            enter_hold = 1'b1;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        ST_HOLD: begin
          if (cnt == HOLD_N) begin
            if (BLANK_CYCLES == 0) begin
              state_nxt = ST_IDLE;
              cnt_nxt   = '0;
            end else begin
              state_nxt = ST_BLANK;
              cnt_nxt   = CW'(1);
            end
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        ST_BLANK: begin
          if (cnt == BLANK_N) begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        default: begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Registered outputs. det_out follows the next state so it rises on the
  // HOLD-entry edge together with det_pulse, the count and the timestamp.
  // -------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      det_out       <= 1'b0;
      det_pulse     <= 1'b0;
      det_timestamp <= '0;
    end else begin
      det_out   <= (state_nxt == ST_HOLD);
      det_pulse <= enter_hold;
      if (enter_hold) det_timestamp <= ts_cnt - TS_LAT;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stats <= '0;
    end else begin
      stats.det <= sat_inc(stats.det, clear_counts, enter_hold);
      stats.rej <= sat_inc(stats.rej, clear_counts, reject);
    end
  end

  assign det_count = stats.det;
  assign rej_count = stats.rej;

endmodule

// File: tb/tb_piezo_rx_detector.sv
// ---------------------------------------------------------------------------
// tb_piezo_rx_detector
// Directed scenarios with constant expectations, then a randomized phase
// compared cycle by cycle against a behavioural model (delay queue for the
// synchroniser, remaining-cycle counters for hold/blank, elapsed-time guard).
// A second instance with TS_WIDTH=8 covers timestamp wrap.
// ---------------------------------------------------------------------------
module tb_piezo_rx_detector;

  localparam int S = 2, F = 4, PH = 8, BL = 100, TG = 10;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic        piezo_raw_in = 1'b0;
  logic        tx_active_in = 1'b0;
  logic        clear_counts = 1'b0;
  logic        det_out, det_pulse;
  logic [31:0] det_timestamp;
  logic [15:0] det_count, rej_count;
  logic        det_out8, det_pulse8;
  logic [7:0]  det_timestamp8;
  logic [15:0] det_count8, rej_count8;

  int n_checks = 0;
  int n_fail   = 0;
  int n_pulses = 0;

  piezo_rx_detector #(.SYNC_STAGES(S), .FILT_LEN(F), .PULSE_HOLD(PH),
                      .BLANK_CYCLES(BL), .TX_GUARD(TG), .TS_WIDTH(32)) dut (
    .clock(clock), .reset_n(reset_n), .enable(enable), .piezo_raw_in(piezo_raw_in),
    .tx_active_in(tx_active_in), .clear_counts(clear_counts), .det_out(det_out),
    .det_pulse(det_pulse), .det_timestamp(det_timestamp), .det_count(det_count),
    .rej_count(rej_count));

  piezo_rx_detector #(.SYNC_STAGES(S), .FILT_LEN(F), .PULSE_HOLD(PH),
                      .BLANK_CYCLES(BL), .TX_GUARD(TG), .TS_WIDTH(8)) dut8 (
    .clock(clock), .reset_n(reset_n), .enable(enable), .piezo_raw_in(piezo_raw_in),
    .tx_active_in(tx_active_in), .clear_counts(clear_counts), .det_out(det_out8),
    .det_pulse(det_pulse8), .det_timestamp(det_timestamp8), .det_count(det_count8),
    .rej_count(rej_count8));

  always #10 clock = ~clock;

  always @(negedge clock) if (det_pulse === 1'b1) n_pulses++;

  // ------------------------------- model ----------------------------------
  bit          m_hist[$];
  int          m_quiet, m_run, m_hold_left, m_blank_left;
  bit          m_tx_seen, m_det, m_pulse;
  logic [31:0] m_ts, m_stamp;
  logic [15:0] m_dcnt, m_rcnt;

  task automatic model_reset();
    m_hist = {};
    for (int i = 0; i < S; i++) m_hist.push_back(1'b0);
    m_quiet = 0; m_tx_seen = 0; m_run = 0; m_hold_left = 0; m_blank_left = 0;
    m_det = 0; m_pulse = 0; m_ts = '0; m_stamp = '0; m_dcnt = '0; m_rcnt = '0;
  endtask

  // One clock edge of the specified behaviour, using the inputs present now.
  task automatic model_edge();
    bit s, g, inc_d, inc_r;
    s = m_hist[0];
    g = tx_active_in || (m_tx_seen && m_quiet < TG);
    inc_d = 0; inc_r = 0; m_pulse = 0;
    if (!enable) begin
      m_run = 0; m_hold_left = 0; m_blank_left = 0;
    end else if (m_hold_left > 0) begin
      m_hold_left--;
      if (m_hold_left == 0) m_blank_left = BL;
    end else if (m_blank_left > 0) begin
      m_blank_left--;
    end else if (m_run > 0) begin
      if (!s) begin m_run = 0; inc_r = 1; end
      else if (g) m_run = 0;
      else m_run++;
    end else if (s && !g) begin
      m_run = 1;
    end
    if (m_run == F) begin
      m_run = 0; m_hold_left = PH; m_pulse = 1; inc_d = 1;
      m_stamp = m_ts - 32'(S + F - 1);
    end
    m_det = (m_hold_left > 0);
    if (clear_counts) begin m_dcnt = '0; m_rcnt = '0; end
    else begin
      if (inc_d && m_dcnt != 16'hFFFF) m_dcnt++;
      if (inc_r && m_rcnt != 16'hFFFF) m_rcnt++;
    end
    m_ts++;
    void'(m_hist.pop_front());
    m_hist.push_back(piezo_raw_in);
    if (tx_active_in) begin m_quiet = 0; m_tx_seen = 1; end
    else if (m_quiet < 1000000) m_quiet++;
  endtask

  // ------------------------------ stimulus --------------------------------
  task automatic step();
    @(posedge clock);
    if (reset_n) model_edge();
    #1;
  endtask

  task automatic pulse(input int n);
    piezo_raw_in = 1'b1;
    repeat (n) step();
    piezo_raw_in = 1'b0;
  endtask

  // ------------------------------- tests ----------------------------------
  task automatic test_reset();
    n_checks++;
    if ({det_out, det_pulse, det_timestamp, det_count, rej_count} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got=%b/%b/%h/%h/%h required=all zero",
               det_out, det_pulse, det_timestamp, det_count, rej_count);
    end
    n_checks++;
    if ({det_out8, det_pulse8, det_timestamp8, det_count8, rej_count8} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs8 got=%b/%b/%h/%h/%h required=all zero",
               det_out8, det_pulse8, det_timestamp8, det_count8, rej_count8);
    end
  endtask

  task automatic test_detect();
    int p0;
    logic exp_hi;
    p0 = n_pulses;
    for (int i = 0; i < 1100 && m_ts != 32'd1000; i++) step();
    piezo_raw_in = 1'b1;
    for (int i = 0; i < 50; i++) begin
      step();
      exp_hi = (m_ts >= 32'd1006 && m_ts <= 32'd1013);
      n_checks++;
      if (det_out !== exp_hi) begin
        n_fail++;
        $display("FAIL detect_level ts=%0d got=%b required=%b", m_ts, det_out, exp_hi);
      end
    end
    piezo_raw_in = 1'b0;
    n_checks++;
    if (n_pulses - p0 != 1) begin
      n_fail++; $display("FAIL detect_pulse_count got=%0d required=1", n_pulses - p0);
    end
    n_checks++;
    if (det_timestamp !== 32'd1000) begin
      n_fail++; $display("FAIL detect_timestamp got=%0d required=1000", det_timestamp);
    end
    n_checks++;
    if (det_count !== 16'd1 || rej_count !== 16'd0) begin
      n_fail++; $display("FAIL detect_counts det=%0d rej=%0d required=1/0", det_count, rej_count);
    end
    repeat (120) step();
  endtask

  task automatic test_blank();
    int p0, t;
    p0 = n_pulses;
    pulse(6);
    t = 0;
    while (det_out !== 1'b0 && t < 20) begin step(); t++; end
    n_checks++;
    if (det_out !== 1'b0) begin
      n_fail++; $display("FAIL blank_drop_timeout got=%b required=0", det_out);
    end
    repeat (20) step();
    pulse(6);
    repeat (10) step();
    n_checks++;
    if (n_pulses - p0 != 1 || det_count !== 16'd2) begin
      n_fail++;
      $display("FAIL blank_ignore pulses=%0d det=%0d required=1/2", n_pulses - p0, det_count);
    end
    repeat (84) step();
    pulse(6);
    repeat (4) step();
    n_checks++;
    if (n_pulses - p0 != 2 || det_count !== 16'd3) begin
      n_fail++;
      $display("FAIL blank_after pulses=%0d det=%0d required=2/3", n_pulses - p0, det_count);
    end
    repeat (120) step();
  endtask

  task automatic test_reject();
    int p0;
    p0 = n_pulses;
    pulse(3);
    repeat (6) step();
    n_checks++;
    if (rej_count !== 16'd1 || det_count !== 16'd3 || n_pulses != p0) begin
      n_fail++;
      $display("FAIL reject_glitch rej=%0d det=%0d pulses=%0d required=1/3/0",
               rej_count, det_count, n_pulses - p0);
    end
  endtask

  task automatic test_tx_guard();
    int p0;
    p0 = n_pulses;
    tx_active_in = 1'b1;
    repeat (5) step();
    tx_active_in = 1'b0;
    repeat (5) step();
    pulse(3);
    repeat (7) step();
    n_checks++;
    if (rej_count !== 16'd1 || n_pulses != p0 || det_count !== 16'd3) begin
      n_fail++;
      $display("FAIL guard_ignore rej=%0d pulses=%0d det=%0d required=1/0/3",
               rej_count, n_pulses - p0, det_count);
    end
    pulse(6);
    repeat (4) step();
    n_checks++;
    if (n_pulses - p0 != 1 || det_count !== 16'd4 || rej_count !== 16'd1) begin
      n_fail++;
      $display("FAIL guard_after pulses=%0d det=%0d rej=%0d required=1/4/1",
               n_pulses - p0, det_count, rej_count);
    end
    repeat (120) step();
  endtask

  task automatic test_enable();
    logic [31:0] e0;
    piezo_raw_in = 1'b1;
    repeat (6) step();
    enable = 1'b0;
    step();
    n_checks++;
    if (det_out !== 1'b0 || det_count !== 16'd5) begin
      n_fail++;
      $display("FAIL enable_off det_out=%b det=%0d required=0/5", det_out, det_count);
    end
    repeat (3) step();
    e0 = m_ts;
    enable = 1'b1;
    repeat (4) step();
    piezo_raw_in = 1'b0;
    n_checks++;
    if (det_out !== 1'b1 || det_count !== 16'd6 || det_timestamp !== e0 - 32'd2) begin
      n_fail++;
      $display("FAIL enable_requal det_out=%b det=%0d ts=%0d required=1/6/%0d",
               det_out, det_count, det_timestamp, e0 - 32'd2);
    end
    repeat (120) step();
  endtask

  task automatic test_reset_mid();
    logic [31:0] t0;
    pulse(6);
    step(); step();
    #3 reset_n = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if (det_out !== 1'b0 || det_count !== 16'd0 || rej_count !== 16'd0 ||
        det_timestamp !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_mid det_out=%b det=%0d rej=%0d ts=%0d required=0/0/0/0",
               det_out, det_count, rej_count, det_timestamp);
    end
    step(); step();
    reset_n = 1'b1;
    repeat (3) step();
    t0 = m_ts;
    pulse(6);
    n_checks++;
    if (det_out !== 1'b1 || det_count !== 16'd1 || det_timestamp !== t0) begin
      n_fail++;
      $display("FAIL reset_recover det_out=%b det=%0d ts=%0d required=1/1/%0d",
               det_out, det_count, det_timestamp, t0);
    end
    repeat (120) step();
  endtask

  task automatic test_wrap();
    logic [31:0] t0;
    for (int i = 0; i < 300 && m_ts[7:0] != 8'd254; i++) step();
    t0 = m_ts;
    piezo_raw_in = 1'b1;
    repeat (5) step();
    clear_counts = 1'b1;
    step();
    clear_counts = 1'b0;
    piezo_raw_in = 1'b0;
    n_checks++;
    if (det_timestamp8 !== 8'd254 || det_out8 !== 1'b1 || det_pulse8 !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_ts8 ts=%0d out=%b pulse=%b required=254/1/1",
               det_timestamp8, det_out8, det_pulse8);
    end
    n_checks++;
    if (det_timestamp !== t0) begin
      n_fail++; $display("FAIL wrap_ts32 got=%0d required=%0d", det_timestamp, t0);
    end
    n_checks++;
    if (det_count !== 16'd0 || det_count8 !== 16'd0 || rej_count !== 16'd0) begin
      n_fail++;
      $display("FAIL wrap_clear det=%0d det8=%0d rej=%0d required=0/0/0",
               det_count, det_count8, rej_count);
    end
    repeat (120) step();
  endtask

  task automatic test_random();
    int run_left, tx_left, dis_left;
    logic [65:0] got_w, exp_w;
    logic [41:0] got8, exp8;
    run_left = 0; tx_left = 0; dis_left = 0;
    for (int i = 0; i < 3000; i++) begin
      if (run_left == 0) begin
        piezo_raw_in = ~piezo_raw_in;
        run_left = piezo_raw_in ? int'($urandom_range(1, 8)) : int'($urandom_range(1, 60));
      end
      run_left--;
      if (tx_left > 0) tx_left--;
      else if ($urandom_range(0, 149) == 0) tx_left = int'($urandom_range(1, 5));
      tx_active_in = (tx_left > 0);
      if (dis_left > 0) dis_left--;
      else if ($urandom_range(0, 299) == 0) dis_left = int'($urandom_range(1, 6));
      enable = (dis_left == 0);
      clear_counts = ($urandom_range(0, 199) == 0);
      step();
      exp_w = {m_det, m_pulse, m_stamp, m_dcnt, m_rcnt};
      got_w = {det_out, det_pulse, det_timestamp, det_count, rej_count};
      n_checks++;
      if (got_w !== exp_w) begin
        n_fail++; $display("FAIL rand_dut cyc=%0d got=%h required=%h", i, got_w, exp_w);
      end
      exp8 = {m_det, m_pulse, m_stamp[7:0], m_dcnt, m_rcnt};
      got8 = {det_out8, det_pulse8, det_timestamp8, det_count8, rej_count8};
      n_checks++;
      if (got8 !== exp8) begin
        n_fail++; $display("FAIL rand_dut8 cyc=%0d got=%h required=%h", i, got8, exp8);
      end
    end
    piezo_raw_in = 1'b0; tx_active_in = 1'b0; enable = 1'b1; clear_counts = 1'b0;
  endtask

  initial begin
    model_reset();
    enable = 1'b1;
    repeat (3) step();
    test_reset();
    reset_n = 1'b1;
    test_detect();
    test_blank();
    test_reject();
    test_tx_guard();
    test_enable();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog time limit reached, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

endmodule
